// File: rtl/risc_ctrl_pkg.sv
// Shared opcode-class and stage encodings for the stage controller, its decoder and benches.
// Optional perf counter in stage_ctrl is enabled by STAGE_CTRL_PERF_EN.
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        OpAlu    = 3'd0,
        OpLoad   = 3'd1,
        OpStore  = 3'd2,
        OpBranch = 3'd3,
        OpJump   = 3'd4,
        OpCall   = 3'd5,
        OpRet    = 3'd6,
        OpStop   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } stage_e;

    localparam int unsigned CountWidth = 32;

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter; increments on each inc_i pulse and wraps at full scale.
module instr_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stage_ctrl.sv
// Multi-cycle instruction stage controller with sticky halt/fault flags.
// Define STAGE_CTRL_PERF_EN to add the instrCount retired-instruction output.
module stage_ctrl
    import risc_ctrl_pkg::*;
(
    input  logic        sysClk,
    input  logic        sysRstN,
    input  logic [2:0]  opClass,
    input  logic        branchTaken,
    input  logic        memReady,
    input  logic        isStackEmpty,
    input  logic        isStackFull,
`ifdef STAGE_CTRL_PERF_EN
    output logic [31:0] instrCount,
`endif
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        regWrite,
    output logic        stackPush,
    output logic        stackPop,
    output logic [2:0]  stage,
    output logic        stopSignal,
    output logic        stackFault
);

    stage_e state_d, state_q;
    op_e    op_d, op_q;
    logic   stop_d, stop_q;
    logic   fault_d, fault_q;

    always_ff @(posedge sysClk or negedge sysRstN) begin
        if (!sysRstN) begin
            state_q <= StFetch;
            op_q    <= OpAlu;
            stop_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            stop_q  <= stop_d;
            fault_q <= fault_d;
        end
    end

    // Class is captured at the end of DECODE so later opClass changes cannot disturb EXEC/MEM.
    assign op_d = (state_q == StDecode) ? op_e'(opClass) : op_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (memReady) state_d = StDecode;
            StDecode: begin
                if (op_e'(opClass) == OpStop) begin
                    state_d = isStackEmpty ? StHalt : StFault;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (op_q)
                    OpAlu:           state_d = StWb;
                    OpLoad, OpStore: state_d = StMem;
                    OpCall:          state_d = isStackFull  ? StFault : StFetch;
                    OpRet:           state_d = isStackEmpty ? StFault : StFetch;
                    default:         state_d = StFetch;
                endcase
            end
            StMem:    if (memReady) state_d = (op_q == OpLoad) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            default:  state_d = state_q;
        endcase
    end

    assign stop_d  = stop_q  | (state_d == StHalt) | (state_d == StFault);
    assign fault_d = fault_q | (state_d == StFault);

    always_comb begin
        memRead   = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        unique case (state_q)
            StFetch: begin
                memRead = 1'b1;
                // Reset holds FETCH; keep the IR/PC load suppressed until it releases.
                irWrite = memReady & sysRstN;
                pcWrite = memReady & sysRstN;
            end
            StExec: begin
                unique case (op_q)
                    OpBranch: pcWrite = branchTaken;
                    OpJump:   pcWrite = 1'b1;
                    OpCall: begin
                        stackPush = ~isStackFull;
                        pcWrite   = ~isStackFull;
                    end
                    OpRet: begin
                        stackPop = ~isStackEmpty;
                        pcWrite  = ~isStackEmpty;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                memRead  = (op_q == OpLoad);
                memWrite = (op_q == OpStore);
            end
            StWb:    regWrite = 1'b1;
            default: ;
        endcase
    end

    assign stage      = state_q;
    assign stopSignal = stop_q;
    assign stackFault = fault_q;

`ifdef STAGE_CTRL_PERF_EN
    logic retire;

    assign retire = (state_d == StFetch) &&
                    (state_q == StExec || state_q == StMem || state_q == StWb);

    instr_counter #(
        .Width (CountWidth)
    ) u_instr_counter (
        .clk_i   (sysClk),
        .rst_ni  (sysRstN),
        .inc_i   (retire),
        .count_o (instrCount)
    );
`endif

endmodule
